// File: rtl/qbert_pkg.sv
// Shared definitions for the Q*bert pyramid blocks: cube tracker states,
// default pyramid size and a one-hot test reused by several controllers.
package qbert_pkg;

    localparam int N_CUBE_DEFAULT = 28;
    localparam int ONEHOT_MAX_W   = 64;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ARMED  = 2'd1,
        COMMIT = 2'd2,
        DONE   = 2'd3
    } cube_state_t;

    // Narrower vectors are zero-extended by the caller; padding never changes one-hotness.
    function automatic logic is_onehot(input logic [ONEHOT_MAX_W-1:0] v);
        return (v != {ONEHOT_MAX_W{1'b0}}) &&
               ((v & (v - 64'd1)) == {ONEHOT_MAX_W{1'b0}});
    endfunction

endpackage

// File: rtl/cube_color_tracker_onehot_check.sv
// Combinational one-hot detector; flags whether a cube vector names exactly one cube.
module onehot_check
    import qbert_pkg::*;
#(
    parameter int W = N_CUBE_DEFAULT
) (
    input  logic [W-1:0] vec_i,
    output logic         onehot_o
);

    logic [ONEHOT_MAX_W-1:0] vec_ext_s;

    // Widen to the helper's fixed width and evaluate.
    always_comb begin
        vec_ext_s = ONEHOT_MAX_W'(vec_i);
        onehot_o  = is_onehot(vec_ext_s);
    end

endmodule

// File: rtl/cube_color_tracker.sv
// Owns the per-cube colour bitmap, lit-cube count, score/fall pulses and
// level completion flag for the pyramid; the bitmap is pre-applied at move start.
module cube_color_tracker
    import qbert_pkg::*;
#(
    parameter int N_CUBE = N_CUBE_DEFAULT,
    parameter int CNT_W  = $clog2(N_CUBE + 1)
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [N_CUBE-1:0] position_qb,
    input  logic [N_CUBE-1:0] e_next_qb,
    input  logic              done_move,
    input  logic              new_level,
    input  logic              toggle_mode,
    output logic [N_CUBE-1:0] e_color_state,
    output logic [CNT_W-1:0]  cube_count,
    output logic              score_pulse,
    output logic              fall_pulse,
    output logic              level_done
);

    cube_state_t       state_q, state_d;
    logic [N_CUBE-1:0] bitmap_q, bitmap_d;
    logic [CNT_W-1:0]  count_q, count_d;
    logic              mode_q, mode_d;
    logic              valid_q, valid_d;
    logic              unlit_q, unlit_d;
    logic              score_q, score_d;
    logic              fall_q, fall_d;
    logic              level_q, level_d;

    logic              target_onehot_s;
    logic              do_commit_s;
    logic              sel_valid_s;
    logic              sel_unlit_s;
    logic              sel_mode_s;

    onehot_check #(.W(N_CUBE)) u_onehot (
        .vec_i    (e_next_qb),
        .onehot_o (target_onehot_s)
    );

    // State register and all registered outputs.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q  <= IDLE;
            bitmap_q <= {N_CUBE{1'b0}};
            count_q  <= {CNT_W{1'b0}};
            mode_q   <= 1'b0;
            valid_q  <= 1'b0;
            unlit_q  <= 1'b0;
            score_q  <= 1'b0;
            fall_q   <= 1'b0;
            level_q  <= 1'b0;
        end else begin
            state_q  <= state_d;
            bitmap_q <= bitmap_d;
            count_q  <= count_d;
            mode_q   <= mode_d;
            valid_q  <= valid_d;
            unlit_q  <= unlit_d;
            score_q  <= score_d;
            fall_q   <= fall_d;
            level_q  <= level_d;
        end
    end

    // Next-state: arm on a position mismatch, settle count/pulses on done_move.
    always_comb begin
        state_d     = state_q;
        bitmap_d    = bitmap_q;
        count_d     = count_q;
        mode_d      = mode_q;
        valid_d     = valid_q;
        unlit_d     = unlit_q;
        score_d     = 1'b0;
        fall_d      = 1'b0;
        level_d     = level_q;
        do_commit_s = 1'b0;
        sel_valid_s = valid_q;
        sel_unlit_s = unlit_q;
        sel_mode_s  = mode_q;

        if (new_level) begin
            state_d  = IDLE;
            bitmap_d = {N_CUBE{1'b0}};
            count_d  = {CNT_W{1'b0}};
            level_d  = 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (position_qb != e_next_qb) begin
                        mode_d      = toggle_mode;
                        valid_d     = target_onehot_s;
                        unlit_d     = ((bitmap_q & e_next_qb) == {N_CUBE{1'b0}});
                        sel_valid_s = target_onehot_s;
                        sel_unlit_s = unlit_d;
                        sel_mode_s  = toggle_mode;
                        if (target_onehot_s) begin
                            bitmap_d = toggle_mode ? (bitmap_q ^ e_next_qb)
                                                   : (bitmap_q | e_next_qb);
                        end else begin
                            bitmap_d = bitmap_q;
                        end
                        // A jump that ends in its own detection cycle commits immediately.
                        if (done_move) begin
                            do_commit_s = 1'b1;
                            state_d     = COMMIT;
                        end else begin
                            state_d     = ARMED;
                        end
                    end else begin
                        state_d = IDLE;
                    end
                end
                ARMED: begin
                    if (done_move) begin
                        do_commit_s = 1'b1;
                        state_d     = COMMIT;
                    end else begin
                        state_d     = ARMED;
                    end
                end
                COMMIT: begin
                    if (count_q == CNT_W'(N_CUBE)) begin
                        state_d = DONE;
                        level_d = 1'b1;
                    end else if (position_qb == e_next_qb) begin
                        state_d = IDLE;
                    end else begin
                        state_d = COMMIT;
                    end
                end
                DONE: begin
                    state_d = DONE;
                end
                default: begin
                    state_d = IDLE;
                end
            endcase

            if (do_commit_s) begin
                if (sel_valid_s) begin
                    if (sel_unlit_s) begin
                        score_d = 1'b1;
                        count_d = (count_q < CNT_W'(N_CUBE)) ? count_q + CNT_W'(1) : count_q;
                    end else if (sel_mode_s) begin
                        count_d = (count_q != {CNT_W{1'b0}}) ? count_q - CNT_W'(1) : count_q;
                    end else begin
                        count_d = count_q;
                    end
                end else begin
                    fall_d = 1'b1;
                end
            end else begin
                fall_d = 1'b0;
            end
        end
    end

    assign e_color_state = bitmap_q;
    assign cube_count    = count_q;
    assign score_pulse   = score_q;
    assign fall_pulse    = fall_q;
    assign level_done    = level_q;

endmodule
